// File: rtl/pcs_gray_pkg.sv
// Shared Gray-code helpers for the pcs counters: width-generic conversions
// and a max-value helper, all operating on a MAX_W-bit container.
package pcs_gray_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    // Step selected for the current cycle, in priority order load > enable > hold.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_e;

    function automatic word_t max_val(input int unsigned w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Upper bits are zero for narrower widths, so the MSB-first prefix still works.
    function automatic word_t gray2bin(input word_t g);
        word_t       b;
        logic        acc;
        int unsigned idx;
        b   = '0;
        acc = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            idx    = MAX_W - 1 - i;
            acc    = acc ^ g[idx];
            b[idx] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/graycounter_param_if.sv
// Control/status bundle of graycounter_param: step/load controls in,
// Gray/binary count and flags out.
interface graycounter_param_if #(
    parameter int WIDTH = 5
);
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] outp;
    logic [WIDTH-1:0] outp_bin;
    logic             tc;
    logic             bound;

    modport master (
        output enable, up_dn, load, load_val,
        input  outp, outp_bin, tc, bound
    );

    modport slave (
        input  enable, up_dn, load, load_val,
        output outp, outp_bin, tc, bound
    );
endinterface

// File: rtl/graycounter_param_gray2bin_comb.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down);
// reusable by consumers of outp in other clock domains.
module gray2bin_comb #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] bin;
    logic             acc;

    always_comb begin
        bin = '0;
        acc = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            acc                = acc ^ gray_i[WIDTH-1-i];
            bin[WIDTH-1-i]     = acc;
        end
    end

    assign bin_o = bin;

endmodule

// File: rtl/graycounter_param.sv
// Parametrised up/down Gray counter with synchronous Gray load, wrap or
// saturate at the bounds, registered Gray/binary outputs and bound pulse.
module graycounter_param
    import pcs_gray_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input logic            clk,
    input logic            reset_n,
    graycounter_param_if.slave io
);

    localparam logic [WIDTH-1:0] MAXV       = WIDTH'(max_val(WIDTH));
    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(word_t'(RESET_VAL)));

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             bound_q, bound_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_max, at_zero;
    op_e              op;

    gray2bin_comb #(.WIDTH(WIDTH)) u_load_g2b (
        .gray_i (io.load_val),
        .bin_o  (load_bin)
    );

    assign at_max  = (bin_q == MAXV);
    assign at_zero = (bin_q == '0);

    always_comb begin
        if (io.load)
            op = OP_LOAD;
        else if (io.enable)
            op = io.up_dn ? OP_UP : OP_DOWN;
        else
            op = OP_HOLD;
    end

    // Bound detection compares before the step; no carry bit is kept.
    always_comb begin
        bin_d   = bin_q;
        bound_d = 1'b0;
        unique case (op)
            OP_LOAD: bin_d = load_bin;
            OP_UP: begin
                if (at_max) begin
                    bound_d = 1'b1;
                    bin_d   = (SATURATE != 0) ? bin_q : '0;
                end else begin
                    bin_d = bin_q + WIDTH'(1);
                end
            end
            OP_DOWN: begin
                if (at_zero) begin
                    bound_d = 1'b1;
                    bin_d   = (SATURATE != 0) ? bin_q : MAXV;
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                end
            end
            default: bin_d = bin_q;
        endcase
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q   <= RESET_BIN;
            gray_q  <= RESET_GRAY;
            bound_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            bound_q <= bound_d;
        end
    end

    assign io.outp     = gray_q;
    assign io.outp_bin = bin_q;
    assign io.bound    = bound_q;
    assign io.tc       = io.up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_graycounter_param.sv
// Directed and randomised checks of graycounter_param in three configurations:
// 5-bit wrap, 3-bit saturate, 4-bit wrap with RESET_VAL=6.
module tb_graycounter_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    graycounter_param_if #(.WIDTH(5)) if5 ();
    graycounter_param_if #(.WIDTH(3)) if3 ();
    graycounter_param_if #(.WIDTH(4)) if4 ();

    graycounter_param #(.WIDTH(5), .SATURATE(0), .RESET_VAL(0)) u_d5 (
        .clk(clk), .reset_n(reset_n), .io(if5));
    graycounter_param #(.WIDTH(3), .SATURATE(1), .RESET_VAL(0)) u_d3 (
        .clk(clk), .reset_n(reset_n), .io(if3));
    graycounter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(6)) u_d4 (
        .clk(clk), .reset_n(reset_n), .io(if4));

    function automatic logic [4:0] m_b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] m_g2b(input logic [4:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3) ^ (g >> 4);
    endfunction

    task automatic clear_inputs();
        if5.enable = 0; if5.up_dn = 0; if5.load = 0; if5.load_val = '0;
        if3.enable = 0; if3.up_dn = 0; if3.load = 0; if3.load_val = '0;
        if4.enable = 0; if4.up_dn = 0; if4.load = 0; if4.load_val = '0;
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (if5.outp !== 5'b00000 || if5.outp_bin !== 5'b00000 || if5.bound !== 1'b0) begin
            nerr++; $display("FAIL reset_d5: outp=%b bin=%b bound=%b want 00000 00000 0", if5.outp, if5.outp_bin, if5.bound);
        end
        nvec++; if (if5.tc !== 1'b1) begin
            nerr++; $display("FAIL reset_tc_down: tc=%b want 1", if5.tc);
        end
        nvec++; if (if4.outp !== 4'b0101 || if4.outp_bin !== 4'b0110 || if4.bound !== 1'b0) begin
            nerr++; $display("FAIL reset_d4: outp=%b bin=%b bound=%b want 0101 0110 0", if4.outp, if4.outp_bin, if4.bound);
        end
        nvec++; if (if3.outp !== 3'b000 || if3.outp_bin !== 3'b000) begin
            nerr++; $display("FAIL reset_d3: outp=%b bin=%b want 000 000", if3.outp, if3.outp_bin);
        end
    endtask

    task automatic test_wrap_up();
        logic [4:0] head [0:8];
        logic [4:0] prev, eg, eb;
        head = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                 5'b00111, 5'b00101, 5'b00100, 5'b01100};
        do_reset();
        if5.up_dn = 1; if5.enable = 1;
        prev = if5.outp;
        for (int s = 1; s <= 33; s++) begin
            tick();
            eb = 5'(s);
            eg = (s <= 8) ? head[s] : m_b2g(eb);
            nvec++; if (if5.outp !== eg || if5.outp_bin !== eb) begin
                nerr++; $display("FAIL wrap_up step %0d: outp=%b bin=%b want %b %b", s, if5.outp, if5.outp_bin, eg, eb);
            end
            nvec++; if (if5.bound !== (s == 32)) begin
                nerr++; $display("FAIL wrap_up_bound step %0d: bound=%b want %b", s, if5.bound, (s == 32));
            end
            nvec++; if ($countones(if5.outp ^ prev) != 1) begin
                nerr++; $display("FAIL wrap_up_onebit step %0d: %b -> %b", s, prev, if5.outp);
            end
            if (s == 31) begin
                nvec++; if (if5.outp !== 5'b10000) begin
                    nerr++; $display("FAIL wrap_up_step31: outp=%b want 10000", if5.outp);
                end
            end
            prev = if5.outp;
        end
        if5.enable = 0;
    endtask

    task automatic test_down_wrap();
        do_reset();
        if5.up_dn = 0; if5.enable = 1;
        tick();
        if5.enable = 0;
        nvec++; if (if5.outp !== 5'b10000 || if5.outp_bin !== 5'b11111 || if5.bound !== 1'b1) begin
            nerr++; $display("FAIL down_wrap: outp=%b bin=%b bound=%b want 10000 11111 1", if5.outp, if5.outp_bin, if5.bound);
        end
        nvec++; if (if5.tc !== 1'b0) begin
            nerr++; $display("FAIL down_wrap_tc: tc=%b want 0", if5.tc);
        end
        tick();
        nvec++; if (if5.bound !== 1'b0 || if5.outp_bin !== 5'b11111) begin
            nerr++; $display("FAIL down_hold: bound=%b bin=%b want 0 11111", if5.bound, if5.outp_bin);
        end
        if5.up_dn = 1;
        #1;
        nvec++; if (if5.tc !== 1'b1) begin
            nerr++; $display("FAIL tc_up_at_max: tc=%b want 1", if5.tc);
        end
    endtask

    task automatic test_load();
        do_reset();
        if5.up_dn = 1; if5.enable = 1; if5.load = 1; if5.load_val = 5'b11010;
        tick();
        if5.load = 0;
        nvec++; if (if5.outp !== 5'b11010 || if5.outp_bin !== 5'b10011 || if5.bound !== 1'b0) begin
            nerr++; $display("FAIL load: outp=%b bin=%b bound=%b want 11010 10011 0", if5.outp, if5.outp_bin, if5.bound);
        end
        tick();
        if5.enable = 0;
        nvec++; if (if5.outp !== 5'b11110 || if5.outp_bin !== 5'b10100) begin
            nerr++; $display("FAIL load_then_up: outp=%b bin=%b want 11110 10100", if5.outp, if5.outp_bin);
        end
    endtask

    task automatic test_direction_change();
        do_reset();
        if5.up_dn = 1; if5.enable = 1;
        tick(); tick(); tick();
        if5.up_dn = 0;
        tick();
        if5.enable = 0;
        nvec++; if (if5.outp_bin !== 5'd2 || if5.outp !== 5'b00011) begin
            nerr++; $display("FAIL dir_change: bin=%b outp=%b want 00010 00011", if5.outp_bin, if5.outp);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] eb;
        do_reset();
        if3.up_dn = 1; if3.enable = 1;
        for (int s = 1; s <= 10; s++) begin
            tick();
            eb = (s >= 7) ? 3'd7 : 3'(s);
            nvec++; if (if3.outp_bin !== eb || if3.outp !== (eb ^ (eb >> 1))) begin
                nerr++; $display("FAIL sat_up step %0d: bin=%b outp=%b want %b", s, if3.outp_bin, if3.outp, eb);
            end
            nvec++; if (if3.bound !== (s >= 8)) begin
                nerr++; $display("FAIL sat_bound step %0d: bound=%b want %b", s, if3.bound, (s >= 8));
            end
            if (s >= 7) begin
                nvec++; if (if3.tc !== 1'b1 || if3.outp !== 3'b100) begin
                    nerr++; $display("FAIL sat_hold step %0d: tc=%b outp=%b want 1 100", s, if3.tc, if3.outp);
                end
            end
        end
        do_reset();
        if3.up_dn = 0; if3.enable = 1;
        tick();
        if3.enable = 0;
        nvec++; if (if3.outp_bin !== 3'd0 || if3.bound !== 1'b1 || if3.tc !== 1'b1) begin
            nerr++; $display("FAIL sat_down: bin=%b bound=%b tc=%b want 000 1 1", if3.outp_bin, if3.bound, if3.tc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        if4.up_dn = 1; if4.enable = 1;
        for (int s = 0; s < 5; s++) tick();
        nvec++; if (if4.outp_bin !== 4'd11) begin
            nerr++; $display("FAIL async_pre: bin=%b want 1011", if4.outp_bin);
        end
        #3 reset_n = 1'b0;
        #1;
        nvec++; if (if4.outp_bin !== 4'b0110 || if4.outp !== 4'b0101 || if4.bound !== 1'b0) begin
            nerr++; $display("FAIL async_reset: bin=%b outp=%b bound=%b want 0110 0101 0", if4.outp_bin, if4.outp, if4.bound);
        end
        tick();
        nvec++; if (if4.outp_bin !== 4'b0110) begin
            nerr++; $display("FAIL async_held: bin=%b want 0110", if4.outp_bin);
        end
        #3 reset_n = 1'b1;
        tick();
        if4.enable = 0;
        nvec++; if (if4.outp_bin !== 4'd7 || if4.outp !== 4'b0100) begin
            nerr++; $display("FAIL async_resume: bin=%b outp=%b want 0111 0100", if4.outp_bin, if4.outp);
        end
    endtask

    task automatic test_random();
        logic [4:0] mb, prev_g;
        logic       mbound, en, up, ld, etc;
        logic [4:0] lv;
        do_reset();
        mb = '0;
        for (int c = 0; c < 10000; c++) begin
            en = 1'($urandom);
            up = 1'($urandom);
            ld = ($urandom_range(0, 15) == 0);
            lv = 5'($urandom);
            if5.enable = en; if5.up_dn = up; if5.load = ld; if5.load_val = lv;
            prev_g = if5.outp;
            mbound = 1'b0;
            if (ld) begin
                mb = m_g2b(lv);
            end else if (en && up) begin
                if (mb == 5'd31) mbound = 1'b1;
                mb = 5'((int'(mb) + 1) % 32);
            end else if (en) begin
                if (mb == 5'd0) mbound = 1'b1;
                mb = 5'((int'(mb) + 31) % 32);
            end
            etc = up ? (mb == 5'd31) : (mb == 5'd0);
            tick();
            nvec++; if (if5.outp_bin !== mb || if5.outp !== m_b2g(mb)) begin
                nerr++; $display("FAIL rand_count cyc %0d: bin=%b outp=%b want %b %b", c, if5.outp_bin, if5.outp, mb, m_b2g(mb));
            end
            nvec++; if (if5.outp !== m_b2g(if5.outp_bin)) begin
                nerr++; $display("FAIL rand_consistent cyc %0d: outp=%b bin=%b", c, if5.outp, if5.outp_bin);
            end
            nvec++; if (if5.bound !== mbound || if5.tc !== etc) begin
                nerr++; $display("FAIL rand_flags cyc %0d: bound=%b tc=%b want %b %b", c, if5.bound, if5.tc, mbound, etc);
            end
            if (en && !ld) begin
                nvec++; if ($countones(if5.outp ^ prev_g) != 1) begin
                    nerr++; $display("FAIL rand_onebit cyc %0d: %b -> %b", c, prev_g, if5.outp);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_wrap_up();
        test_down_wrap();
        test_load();
        test_direction_change();
        test_saturate();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/graycounter_param.md
Name: graycounter_param

Overview:
Parametrised Gray-code counter, successor to the fixed 5-bit/8-state Gray counters in pcs25g.
- Generic width; up/down counting; synchronous Gray-coded load; wrap or saturate mode.
- Registered Gray and binary outputs, plus terminal-count and bound-event flags.
- Used for FIFO pointers, lane-alignment timers and gearbox phase tracking.
- The Gray output is registered directly, so it is safe to sample from another clock domain (one bit changes per step).

Parameters:
WIDTH, 5, counter width in bits (>=2); full range 0..2^WIDTH-1.
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = hold at bounds.
RESET_VAL, 0, binary reset value (< 2^WIDTH); loaded into both output registers at reset.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  count one step this cycle
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of load_val
load_val  input  WIDTH  Gray-coded value to load
outp  output  WIDTH  registered Gray count
outp_bin  output  WIDTH  registered binary equivalent of outp
tc  output  1  combinational: count is at bound for current direction (all-max when up_dn=1, zero when up_dn=0)
bound  output  1  registered one-cycle pulse: a step crossed (wrap) or hit (saturate) a bound

Behaviour:
- Reset (reset_n low, asynchronous):
  - outp_bin = RESET_VAL; outp = RESET_VAL ^ (RESET_VAL>>1); bound = 0.
  - Deassertion is synchronised externally; the block takes no action on the first edge after release beyond normal operation.
- State: the binary register is authoritative. The Gray register is always the registered bin2gray of the next binary value, so outp and outp_bin update on the same edge (latency 1 from enable/load).
- Priority each rising edge: load > enable > hold.
- load=1:
  - outp_bin <= gray2bin(load_val); outp <= load_val.
  - bound <= 0. enable is ignored. load_val is not required to be adjacent to the current value.
- enable=1, load=0, up_dn=1:
  - Below max: bin+1.
  - At max (2^WIDTH-1), SATURATE=0: wrap to 0 and bound <= 1.
  - At max, SATURATE=1: hold and bound <= 1.
- enable=1, load=0, up_dn=0:
  - Above 0: bin-1.
  - At 0, SATURATE=0: wrap to 2^WIDTH-1 and bound <= 1.
  - At 0, SATURATE=1: hold and bound <= 1.
- enable=0, load=0: hold all state; bound <= 0.
- bound is 0 in every cycle that did not see a bound event; it is not sticky.
- tc = up_dn ? (outp_bin == all-ones) : (outp_bin == 0). It is purely combinational from registered state and up_dn, and it is independent of enable.
- Direction change is legal on any cycle; the next step uses the new up_dn, with no turnaround cycle.
- Invariant: for every enabled non-load step, outp changes in exactly one bit. This holds on wrap as well (Gray max = 1 followed by zeros; max -> 0 flips only the MSB).
- Arithmetic: modulo 2^WIDTH, with no extra carry bit stored; saturation is detected by comparing against the bound before the increment.
- Reset asserted mid-operation overrides any load/enable in flight; outputs go to reset values immediately.

Decomposition:
- Shared package pcs_gray_pkg:
  - functions bin2gray(width-generic) and gray2bin(width-generic);
  - localparam helpers for the max value.
- One natural sub-module, gray2bin_comb: combinational XOR-prefix converter used on load_val. It can be reused by consumers of outp in other clock domains.
- bin2gray is inline (single XOR) and needs no sub-module.

Test Plan:
- WIDTH=5, SATURATE=0, up_dn=1, enable held 33 cycles after reset:
  - outp sequence 00000, 00001, 00011, 00010, 00110, 00111, 00101, 00100, 01100, ...; after step 31 outp = 10000.
  - Step 32 -> 00000 with bound=1 for exactly that cycle.
  - The checker asserts a single-bit change on every step.
- WIDTH=5 from reset, up_dn=0, one enable:
  - outp = 10000, outp_bin = 11111, bound=1.
  - tc=1 at reset (bin 0, down); tc=0 after the step.
- WIDTH=5, load=1 with load_val=11010 while enable=1:
  - Next cycle outp=11010, outp_bin=10011 (19), bound=0.
  - Then an up step gives outp=11110, outp_bin=10100 (20).
- WIDTH=3, SATURATE=1, up_dn=1, 10 enables from 0:
  - Reaches outp=100 (bin 111) after 7 steps; holds there.
  - bound=1 on each of the 3 further enables; tc=1 throughout the hold.
- WIDTH=4, RESET_VAL=6, counting up:
  - Assert reset_n low asynchronously mid-cycle at count 11.
  - Outputs go immediately to outp_bin=0110, outp=0101, bound=0.
  - Counting resumes from 6 after release.
- Random enable/up_dn/load over 10k cycles against a behavioural model:
  - outp == bin2gray(outp_bin) every cycle.
  - Step results match the model; bound and tc match the model.
